// File: rtl/mux_tree_pipe_pkg.sv
// Shared helpers for the pipelined mux tree: select-width function, lane
// offset helper and the padded lane count of the default configuration.
package mux_tree_pkg;

   // Smallest r with 2**r >= n; used to derive the select width / tree depth.
   function automatic int clog2(input int n);
      int r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   // Bit offset of lane 'lane' in a flat vector of 'width'-bit lanes.
   function automatic int lane_slice(input int lane, input int width);
      return lane * width;
   endfunction

   localparam int DEF_WIDTH  = 32;
   localparam int DEF_NUM_IN = 32;
   localparam int DEF_SEL_W  = clog2(DEF_NUM_IN);
   localparam int PAD_IN     = 2 ** DEF_SEL_W;

endpackage

// File: rtl/mux_tree_stage.sv
// One level of the mux tree: halves the lane count using the MSB of the
// remaining select, then registers valid, surviving lanes and the leftover
// select bits. Holds when the pipe stalls, drops the valid on flush.
module mux_tree_stage
   import mux_tree_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int LANES_IN = 2,
   parameter int SELR_W   = 1
) (
   input  logic                                         clk,
   input  logic                                         reset,
   input  logic                                         flush,
   input  logic                                         advance,
   input  logic                                         in_valid,
   input  logic [LANES_IN*WIDTH-1:0]                    in_lanes,
   input  logic [SELR_W-1:0]                            in_selr,
   output logic                                         out_valid,
   output logic [(LANES_IN/2)*WIDTH-1:0]                out_lanes,
   output logic [((SELR_W > 1) ? SELR_W - 1 : 1)-1:0]   out_selr
);

   localparam int LANES_OUT = LANES_IN / 2;
   localparam int REM_W     = (SELR_W > 1) ? SELR_W - 1 : 1;

   logic                         sel_bit;
   logic [REM_W-1:0]             rem_sel;
   logic [LANES_OUT*WIDTH-1:0]   mux_lanes;

   logic                         valid_d, valid_q;
   logic [LANES_OUT*WIDTH-1:0]   lanes_d, lanes_q;
   logic [REM_W-1:0]             selr_d,  selr_q;

   assign sel_bit = in_selr[SELR_W-1];

   if (SELR_W > 1) begin : g_rem
      assign rem_sel = in_selr[SELR_W-2:0];
   end else begin : g_no_rem
      assign rem_sel = '0;
   end

   // Lane j of the result picks upper-half lane j when the select bit is set.
   always_comb begin
      mux_lanes = '0;
      for (int j = 0; j < LANES_OUT; j++) begin
         mux_lanes[lane_slice(j, WIDTH) +: WIDTH] = sel_bit
            ? in_lanes[lane_slice(j + LANES_OUT, WIDTH) +: WIDTH]
            : in_lanes[lane_slice(j, WIDTH) +: WIDTH];
      end
   end

   // Next state: load from the predecessor on advance, hold otherwise; flush drops the valid.
   // NOTE: every _d gets its hold value first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      valid_d = valid_q;
      lanes_d = lanes_q;
      selr_d  = selr_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (advance) begin
         valid_d = in_valid;
         lanes_d = mux_lanes;
         selr_d  = rem_sel;
      end
   end

   // Stage register with synchronous reset.
   // NOTE: non-blocking assignments so every flop samples the pre-edge values of its neighbours.
   // NOTE: the data flops are reset as well because out_data must read 0 straight out of reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         lanes_q <= '0;
         selr_q  <= '0;
      end else begin
         valid_q <= valid_d;
         lanes_q <= lanes_d;
         selr_q  <= selr_d;
      end
   end

   assign out_valid = valid_q;
   assign out_lanes = lanes_q;
   assign out_selr  = selr_q;

endmodule

// File: rtl/mux_tree_pipe.sv
// Pipelined NUM_IN-to-1 word multiplexer, one 2:1 level and one register per
// select bit, valid/ready handshake with whole-pipe stall and flush.
// Optional sticky out-of-range select flag: define MUX_TREE_PIPE_SEL_CHK_EN.
module mux_tree_pipe
   import mux_tree_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int NUM_IN = DEF_NUM_IN,
   parameter int SEL_W  = clog2(NUM_IN)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    flush,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [SEL_W-1:0]        in_sel,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [WIDTH-1:0]        out_data,
   output logic                    err
);

   localparam int PAD_LANES = 2 ** SEL_W;

   logic                       advance;
   logic [PAD_LANES*WIDTH-1:0] in_padded;
   logic                       unused_selr;

   assign advance  = ~out_valid | out_ready;
   assign in_ready = advance & ~flush;

   // Zero-fill the lanes beyond NUM_IN so out-of-range selects yield 0.
   always_comb begin
      in_padded                       = '0;
      in_padded[NUM_IN*WIDTH-1:0]     = in_data;
   end

   for (genvar k = 0; k < SEL_W; k++) begin : g_stage
      localparam int LIN = PAD_LANES >> k;
      localparam int SRW = SEL_W - k;
      localparam int ORW = (SRW > 1) ? SRW - 1 : 1;

      logic                       valid_in;
      logic [LIN*WIDTH-1:0]       lanes_in;
      logic [SRW-1:0]             selr_in;
      logic                       valid_out;
      logic [(LIN/2)*WIDTH-1:0]   lanes_out;
      logic [ORW-1:0]             selr_out;

      if (k == 0) begin : g_first
         assign valid_in = in_valid & in_ready;
         assign lanes_in = in_padded;
         assign selr_in  = in_sel;
      end else begin : g_next
         assign valid_in = g_stage[k-1].valid_out;
         assign lanes_in = g_stage[k-1].lanes_out;
         assign selr_in  = g_stage[k-1].selr_out;
      end

      mux_tree_stage #(
         .WIDTH    (WIDTH),
         .LANES_IN (LIN),
         .SELR_W   (SRW)
      ) u_stage (
         .clk       (clk),
         .reset     (reset),
         .flush     (flush),
         .advance   (advance),
         .in_valid  (valid_in),
         .in_lanes  (lanes_in),
         .in_selr   (selr_in),
         .out_valid (valid_out),
         .out_lanes (lanes_out),
         .out_selr  (selr_out)
      );
   end

   assign out_valid   = g_stage[SEL_W-1].valid_out;
   assign out_data    = g_stage[SEL_W-1].lanes_out;
   // The last stage has no select bits left; its select remainder output is unused.
   assign unused_selr = ^g_stage[SEL_W-1].selr_out;

`ifdef MUX_TREE_PIPE_SEL_CHK_EN
   localparam logic [SEL_W:0] NUM_IN_CMP = (SEL_W + 1)'(NUM_IN);

   logic sel_oob;
   logic err_d, err_q;

   assign sel_oob = ({1'b0, in_sel} >= NUM_IN_CMP);

   // Sticky flag: set on accepting an out-of-range select, cleared only by reset.
   always_comb begin
      err_d = err_q | (in_valid & in_ready & sel_oob);
   end

   // Error flag register; flush deliberately leaves it alone.
   always_ff @(posedge clk) begin
      if (reset) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule
